// File: rtl/kmap_response_checker_if.sv
// Handshake and result bundle between a checker and the environment that
// supplies run control and the reference/DUT responses.
interface kmap_response_checker_if;
  logic        start;
  logic        abort;
  logic [3:0]  x;
  logic        f_ref;
  logic        f_dut;
  logic        busy;
  logic        done;
  logic [15:0] errors;
  logic        first_err_valid;
  logic [19:0] first_err_idx;
  logic [19:0] samples;

  // Checker side: drives stimulus and results.
  modport master (
    input  start, abort, f_ref, f_dut,
    output x, busy, done, errors, first_err_valid, first_err_idx, samples
  );

  // Environment side: drives run control and the two responses.
  modport slave (
    output start, abort, f_ref, f_dut,
    input  x, busy, done, errors, first_err_valid, first_err_idx, samples
  );
endinterface

// File: rtl/kmap_response_checker.sv
// Drives a pseudo-random 4-bit stimulus from a Galois LFSR, compares the
// reference and DUT responses once per cycle and tallies mismatches.
module kmap_response_checker #(
  parameter int unsigned SAMPLES = 100,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input logic                     clk,
  input logic                     resetn,
  kmap_response_checker_if.master bus
);

  // An all-zero seed would lock the LFSR, so substitute 1.
  localparam logic [15:0] LoadVal = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TapMask = 16'hB400;
  localparam logic [19:0] LastCnt = 20'(SAMPLES);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] errors_q, errors_d;
  logic [19:0] samples_q, samples_d;
  logic        fev_q, fev_d;
  logic [19:0] fidx_q, fidx_d;
  logic        mismatch;

  assign mismatch = bus.f_ref ^ bus.f_dut;

  // Next-state: start loads a fresh run, abort wins over the compare in RUN.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    errors_d  = errors_q;
    samples_d = samples_q;
    fev_d     = fev_q;
    fidx_d    = fidx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StRun;
          lfsr_d    = LoadVal;
          errors_d  = 16'h0000;
          samples_d = 20'h00000;
          fev_d     = 1'b0;
          fidx_d    = 20'h00000;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TapMask : 16'h0000);
          samples_d = samples_q + 20'd1;
          if (mismatch) begin
            if (errors_q != 16'hFFFF) begin
              errors_d = errors_q + 16'd1;
            end
            if (!fev_q) begin
              fev_d  = 1'b1;
              fidx_d = samples_q;
            end
          end
          if (samples_d == LastCnt) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and run counters; reset clears everything without a clock.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      lfsr_q    <= LoadVal;
      errors_q  <= 16'h0000;
      samples_q <= 20'h00000;
      fev_q     <= 1'b0;
      fidx_q    <= 20'h00000;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      errors_q  <= errors_d;
      samples_q <= samples_d;
      fev_q     <= fev_d;
      fidx_q    <= fidx_d;
    end
  end

  assign bus.x               = (state_q == StRun) ? lfsr_q[3:0] : 4'h0;
  assign bus.busy            = (state_q == StRun);
  assign bus.done            = (state_q == StDone);
  assign bus.errors          = errors_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx   = fidx_q;
  assign bus.samples         = samples_q;

endmodule

// File: tb/tb_kmap_response_checker.sv
// Randomised bench: a run-level model predicts every output of the main
// instance each cycle; a 70000-sample instance and a one-sample, zero-seed
// instance run alongside for saturation and boundary behaviour.
module tb_kmap_response_checker;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic resetn_b = 1'b1;
  always #5 clk = ~clk;

  kmap_response_checker_if mb ();
  kmap_response_checker_if bb ();
  kmap_response_checker_if ob ();

  logic [15:0] tt_m, tt_b, tt_o;
  bit          flip_q = 1'b0;
  int          mode = 0;
  bit          rnd_flip [128];
  logic [15:0] seq [128];

  assign mb.f_ref = tt_m[mb.x];
  assign mb.f_dut = tt_m[mb.x] ^ flip_q;
  assign bb.f_ref = tt_b[bb.x];
  assign bb.f_dut = ~tt_b[bb.x];
  assign ob.f_ref = tt_o[ob.x];
  assign ob.f_dut = ~tt_o[ob.x];

  kmap_response_checker #(.SAMPLES(100), .SEED(16'hACE1)) u_main (
    .clk(clk), .resetn(resetn), .bus(mb)
  );
  kmap_response_checker #(.SAMPLES(70000), .SEED(16'hACE1)) u_big (
    .clk(clk), .resetn(resetn_b), .bus(bb)
  );
  kmap_response_checker #(.SAMPLES(1), .SEED(16'h0000)) u_one (
    .clk(clk), .resetn(resetn), .bus(ob)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic bit flip_fn(input int idx);
    case (mode)
      1:       return 1'b1;
      2:       return rnd_flip[idx];
      3:       return (idx == 37) || (idx == 60);
      default: return 1'b0;
    endcase
  endfunction

  // Run-level model of the main instance: a run visits sample indices
  // 0..99, the stimulus for sample i is the i-th LFSR state.
  localparam int PIdle = 0, PRun = 1, PDone = 2;
  int m_phase = PIdle, m_samples = 0, m_errors = 0, m_fidx = 0;
  bit m_fev = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_phase = PIdle; m_samples = 0; m_errors = 0; m_fev = 0; m_fidx = 0;
    end else if (m_phase != PRun) begin
      if (mb.start) begin
        m_phase = PRun; m_samples = 0; m_errors = 0; m_fev = 0; m_fidx = 0;
      end
    end else if (mb.abort) begin
      m_phase = PIdle;
    end else begin
      if (flip_fn(m_samples)) begin
        if (m_errors < 65535) m_errors++;
        if (!m_fev) begin
          m_fev = 1'b1; m_fidx = m_samples;
        end
      end
      m_samples++;
      if (m_samples == 100) m_phase = PDone;
    end
  end

  always @(negedge clk) flip_q = flip_fn(m_samples);

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    logic [3:0] ex;
    ex = (m_phase == PRun) ? seq[m_samples][3:0] : 4'h0;
    chk("x", 32'(mb.x), 32'(ex));
    chk("busy", 32'(mb.busy), 32'(m_phase == PRun));
    chk("done", 32'(mb.done), 32'(m_phase == PDone));
    chk("errors", 32'(mb.errors), 32'(m_errors));
    chk("first_err_valid", 32'(mb.first_err_valid), 32'(m_fev));
    chk("first_err_idx", 32'(mb.first_err_idx), 32'(m_fidx));
    chk("samples", 32'(mb.samples), 32'(m_samples));
  end

  task automatic pulse_start();
    mb.start = 1'b1;
    @(negedge clk);
    mb.start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!mb.done && edges < 300) begin
      @(negedge clk);
      edges++;
    end
    if (!mb.done) chk("done_timeout", 32'(mb.done), 32'd1);
  endtask

  task automatic wait_samples(input int n);
    int t = 0;
    while (m_samples != n && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("reach_samples", 32'(mb.samples), 32'(n));
  endtask

  initial begin
    int edges, cnt, big_start, n;
    seq[0] = 16'hACE1;
    for (int i = 1; i < 128; i++)
      seq[i] = (seq[i-1] >> 1) ^ (seq[i-1][0] ? 16'hB400 : 16'h0000);
    tt_m = 16'($urandom); tt_b = 16'($urandom); tt_o = 16'($urandom);
    mb.start = 0; mb.abort = 0; bb.start = 0; bb.abort = 0; ob.start = 0; ob.abort = 0;
    #1 resetn = 1'b0; resetn_b = 1'b0;
    @(negedge clk);
    chk("rst_x", 32'(mb.x), 32'd0);
    chk("rst_busy", 32'(mb.busy), 32'd0);
    chk("rst_done", 32'(mb.done), 32'd0);
    chk("rst_samples", 32'(mb.samples), 32'd0);
    @(negedge clk);
    resetn = 1'b1; resetn_b = 1'b1;
    @(negedge clk);

    // Clean run; all three instances start together; start re-pulsed mid-run.
    mode = 0;
    mb.start = 1; bb.start = 1; ob.start = 1;
    @(negedge clk);
    mb.start = 0; bb.start = 0; ob.start = 0;
    big_start = cyc;
    chk("first_x", 32'(mb.x), 32'h1);
    chk("one_busy", 32'(ob.busy), 32'd1);
    chk("one_seed0_x", 32'(ob.x), 32'h1);
    @(negedge clk);
    chk("second_x", 32'(mb.x), 32'h0);
    chk("one_done", 32'(ob.done), 32'd1);
    chk("one_samples", 32'(ob.samples), 32'd1);
    chk("one_errors", 32'(ob.errors), 32'd1);
    chk("one_fidx", 32'(ob.first_err_idx), 32'd0);
    @(negedge clk);
    chk("third_x", 32'(mb.x), 32'h8);
    edges = 2;
    while (!mb.done && edges < 300) begin
      mb.start = (edges == 20);
      @(negedge clk);
      edges++;
    end
    mb.start = 0;
    chk("clean_latency", 32'(edges), 32'd100);
    chk("clean_errors", 32'(mb.errors), 32'd0);
    chk("clean_fev", 32'(mb.first_err_valid), 32'd0);
    chk("clean_samples", 32'(mb.samples), 32'd100);

    // Inverted DUT, started from DONE.
    mode = 1; tt_m = 16'($urandom);
    pulse_start();
    chk("restart_samples", 32'(mb.samples), 32'd0);
    chk("restart_errors", 32'(mb.errors), 32'd0);
    wait_done(edges);
    chk("inv_latency", 32'(edges), 32'd100);
    chk("inv_errors", 32'(mb.errors), 32'd100);
    chk("inv_fev", 32'(mb.first_err_valid), 32'd1);
    chk("inv_fidx", 32'(mb.first_err_idx), 32'd0);

    // Mismatch only at samples 37 and 60.
    mode = 3; tt_m = 16'($urandom);
    pulse_start();
    wait_done(edges);
    chk("two_errors", 32'(mb.errors), 32'd2);
    chk("two_fidx", 32'(mb.first_err_idx), 32'd37);

    // Random mismatches, abort at 10, abort while idle, start+abort together.
    mode = 2; tt_m = 16'($urandom);
    cnt = 0;
    for (int i = 0; i < 128; i++) begin
      rnd_flip[i] = 1'($urandom);
      if (i < 100) cnt += int'(rnd_flip[i]);
    end
    pulse_start();
    wait_samples(10);
    mb.abort = 1;
    @(negedge clk);
    chk("abort_busy", 32'(mb.busy), 32'd0);
    chk("abort_samples", 32'(mb.samples), 32'd10);
    repeat (3) @(negedge clk);
    chk("idle_abort_busy", 32'(mb.busy), 32'd0);
    mb.start = 1;
    @(negedge clk);
    mb.start = 0; mb.abort = 0;
    chk("start_wins", 32'(mb.busy), 32'd1);
    wait_done(edges);
    chk("rand_errors", 32'(mb.errors), 32'(cnt));

    // Asynchronous reset mid-run, then a fresh run.
    pulse_start();
    wait_samples(50);
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(mb.busy), 32'd0);
    chk("arst_x", 32'(mb.x), 32'd0);
    chk("arst_samples", 32'(mb.samples), 32'd0);
    chk("arst_errors", 32'(mb.errors), 32'd0);
    chk("arst_fidx", 32'(mb.first_err_idx), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    mode = 0;
    pulse_start();
    wait_done(edges);
    chk("post_rst_latency", 32'(edges), 32'd100);
    chk("post_rst_errors", 32'(mb.errors), 32'd0);

    // Long run must saturate its error counter.
    n = 0;
    while (!bb.done && n < 71000) begin
      @(negedge clk);
      n++;
    end
    chk("big_done", 32'(bb.done), 32'd1);
    chk("big_latency", 32'(cyc - big_start), 32'd70000);
    chk("big_errors", 32'(bb.errors), 32'hFFFF);
    chk("big_samples", 32'(bb.samples), 32'd70000);
    chk("big_fidx", 32'(bb.first_err_idx), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kmap_response_checker.md
KMAP_RESPONSE_CHECKER -- requirements
Module: kmap_response_checker

Interface
REQ-001: Parameter SAMPLES, default 100, number of compared samples per run; legal range 1..1048575.
REQ-002: Parameter SEED, default 16'hACE1, LFSR load value; SEED=0 SHALL be replaced by 16'h0001.
REQ-003: clk  input  1  single clock; all state changes on its rising edge.
REQ-004: resetn  input  1  asynchronous, active-low reset.
REQ-005: start  input  1  run request, sampled on the rising edge.
REQ-006: abort  input  1  terminates a run in progress.
REQ-007: x  output  4  stimulus to the reference and DUT combinational functions.
REQ-008: f_ref  input  1  reference response to the current x.
REQ-009: f_dut  input  1  DUT response to the current x.
REQ-010: busy  output  1  high while a run is in progress.
REQ-011: done  output  1  high while results of a completed run are held.
REQ-012: errors  output  16  mismatch count for the current or last run.
REQ-013: first_err_valid  output  1  at least one mismatch recorded this run.
REQ-014: first_err_idx  output  20  0-based index of the first mismatching sample.
REQ-015: samples  output  20  samples compared so far this run.

Function
REQ-016: The block SHALL implement the states IDLE, RUN and DONE; busy=1 only in RUN and done=1 only in DONE.
REQ-017: IDLE or DONE with start=1 at an edge -> RUN; that edge SHALL load LFSR=SEED and clear errors, samples, first_err_valid and first_err_idx.
REQ-018: start in RUN SHALL be ignored.
REQ-019: The LFSR SHALL be 16-bit Galois, right-shifting, tap mask 16'hB400, advancing once per RUN cycle.
REQ-020: x SHALL equal LFSR[3:0] in RUN and 4'h0 in IDLE and DONE.
REQ-021: At each rising edge in RUN, the block SHALL compare f_ref with f_dut for the x currently driven, then increment samples and advance the LFSR.
REQ-022: On a mismatch, errors SHALL increment and saturate at 16'hFFFF.
REQ-023: The first mismatch of a run SHALL set first_err_valid=1 and first_err_idx=samples (pre-increment value); later mismatches SHALL NOT change first_err_idx.
REQ-024: The edge that makes samples equal SAMPLES SHALL move the state to DONE, so done rises exactly SAMPLES edges after the start edge.
REQ-025: DONE SHALL hold errors, samples, first_err_valid and first_err_idx stable until the next start.
REQ-026: abort=1 in RUN SHALL take precedence over the comparison on that edge: no compare takes place, the state moves to IDLE, and counters are held.
REQ-027: abort in IDLE or DONE SHALL have no effect.
REQ-028: With start=1 and abort=1 on the same edge in IDLE or DONE, start SHALL win.
REQ-029: With SAMPLES=1, the state SHALL go RUN -> DONE after exactly one compare edge.

Reset
REQ-030: resetn=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, LFSR=SEED
- x=0, busy=0, done=0
- errors=0, samples=0, first_err_valid=0, first_err_idx=0
REQ-031: Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.
REQ-032: The first start edge after resetn rises SHALL be honoured.

Verification
REQ-033: f_dut tied to f_ref, SAMPLES=100, pulse start -> done=1 exactly 100 edges later, errors=0, first_err_valid=0, samples=100.
REQ-034: f_dut = ~f_ref, SAMPLES=100 -> errors=100, first_err_valid=1, first_err_idx=0.
REQ-035: f_dut forced different from f_ref only while samples=37 and samples=60 -> errors=2, first_err_idx=37; x sequence matches a reference LFSR model from 16'hACE1.
REQ-036: resetn pulsed low at samples=50 -> all outputs 0 asynchronously; next start gives a full fresh run with an identical x sequence.
REQ-037: SAMPLES=70000, f_dut = ~f_ref -> errors=16'hFFFF (saturated), samples=70000, done=1.
REQ-038: Directed control checks:
- start re-pulsed during RUN -> ignored.
- abort at samples=10 -> IDLE with samples=10 held.
- start in DONE -> counters cleared and a new run begins.
